// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register controller.
// Opcodes, operands, the stored word layout and controller states.
package instr_register_pkg;

    localparam int NUM_ENTRIES_DEF = 32;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/instr_reg_rr_arb.sv
// Two-way round-robin arbiter with a one-hot grant.
// The last-grant index only moves when the grant is actually used.
module instr_reg_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    // Pick the sole requester, or the one not served last on a tie.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

    // Remember who won once the winner's write is taken.
    always_comb begin
        last_d = last_q;
        if (update && (grant != 2'b00)) begin
            last_d = grant[1];
        end
    end

    // Requester 1 counts as last winner so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/instr_register_ctrl.sv
// Instruction register controller: clears storage, then runs a
// two-requester write queue with a registered pop port.
module instr_register_ctrl
    import instr_register_pkg::*;
#(
    parameter  int NUM_ENTRIES = NUM_ENTRIES_DEF,
    localparam int PW          = $clog2(NUM_ENTRIES),
    localparam int CW          = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  opcode_t       req0_opcode,
    input  operand_t      req0_op_a,
    input  operand_t      req0_op_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  opcode_t       req1_opcode,
    input  operand_t      req1_op_a,
    input  operand_t      req1_op_b,
    input  logic          rd_req,
    output logic          rd_valid,
    output instruction_t  rd_word,
    input  logic          flush,
    output logic          busy,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          ir_load_en,
    output logic [PW-1:0] ir_write_pointer,
    output opcode_t       ir_opcode,
    output operand_t      ir_operand_a,
    output operand_t      ir_operand_b,
    output logic [PW-1:0] ir_read_pointer,
    input  instruction_t  ir_instruction_word
);

    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_ENTRIES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(NUM_ENTRIES);

    ctrl_state_t   state_q, state_d;
    logic [PW-1:0] clr_ptr_q, clr_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_valid_q, rd_valid_d;
    instruction_t  rd_word_q, rd_word_d;

    logic [1:0] grant;
    logic       run_go;
    logic       wr_acc;
    logic       pop;

    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign busy   = (state_q == INIT);
    assign run_go = (state_q == RUN) && !flush;
    assign wr_acc = run_go && !full && (grant != 2'b00);
    assign pop    = run_go && rd_req && !empty;

    assign req0_ready      = wr_acc && grant[0];
    assign req1_ready      = wr_acc && grant[1];
    assign count           = count_q;
    assign rd_valid        = rd_valid_q;
    assign rd_word         = rd_word_q;
    assign ir_read_pointer = rd_ptr_q;

    instr_reg_rr_arb u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({req1_valid, req0_valid}),
        .update (wr_acc),
        .grant  (grant)
    );

    // Register-side write port: clearing zeros or the winner's word.
    always_comb begin
        ir_load_en       = 1'b0;
        ir_write_pointer = wr_ptr_q;
        ir_opcode        = ZERO;
        ir_operand_a     = '0;
        ir_operand_b     = '0;
        if ((state_q == INIT) && !reset) begin
            ir_load_en       = 1'b1;
            ir_write_pointer = clr_ptr_q;
        end else if (wr_acc) begin
            ir_load_en = 1'b1;
            if (grant[1]) begin
                ir_opcode    = req1_opcode;
                ir_operand_a = req1_op_a;
                ir_operand_b = req1_op_b;
            end else begin
                ir_opcode    = req0_opcode;
                ir_operand_a = req0_op_a;
                ir_operand_b = req0_op_b;
            end
        end
    end

    // Next state: clear sweep, flush, and queue pointer/count updates.
    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = 1'b0;
        rd_word_d  = rd_word_q;
        unique case (state_q)
            INIT: begin
                if (clr_ptr_q == LAST_IDX) begin
                    clr_ptr_d = '0;
                    state_d   = RUN;
                end else begin
                    clr_ptr_d = clr_ptr_q + PW'(1);
                end
            end
            RUN: begin
                if (flush) begin
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    count_d   = '0;
                    clr_ptr_d = '0;
                    state_d   = INIT;
                end else begin
                    if (wr_acc) begin
                        wr_ptr_d = (wr_ptr_q == LAST_IDX) ?
                                   '0 : wr_ptr_q + PW'(1);
                    end
                    if (pop) begin
                        rd_ptr_d   = (rd_ptr_q == LAST_IDX) ?
                                     '0 : rd_ptr_q + PW'(1);
                        rd_valid_d = 1'b1;
                        rd_word_d  = ir_instruction_word;
                    end
                    if (wr_acc && !pop) begin
                        count_d = count_q + CW'(1);
                    end else if (pop && !wr_acc) begin
                        count_d = count_q - CW'(1);
                    end
                end
            end
        endcase
    end

    // State registers; reset restarts the clearing sweep at address 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= INIT;
            clr_ptr_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_word_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_word_q  <= rd_word_d;
        end
    end

endmodule

// File: tb/tb_instr_register_ctrl.sv
// Bench for instr_register_ctrl: cycle model plus queue scoreboard,
// a table of arbitration vectors and hand-written corner sequences.
module tb_instr_register_ctrl;
    import instr_register_pkg::*;

    localparam int N  = 32;
    localparam int PW = 5;
    localparam int CW = 6;

    logic          clk;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    opcode_t       req0_opcode, req1_opcode;
    operand_t      req0_op_a, req0_op_b, req1_op_a, req1_op_b;
    logic          rd_req, rd_valid;
    instruction_t  rd_word;
    logic          flush, busy, full, empty;
    logic [CW-1:0] count;
    logic          ir_load_en;
    logic [PW-1:0] ir_write_pointer, ir_read_pointer;
    opcode_t       ir_opcode;
    operand_t      ir_operand_a, ir_operand_b;
    instruction_t  ir_instruction_word;

    instruction_t mem [N];

    instr_register_ctrl #(.NUM_ENTRIES(N)) dut (
        .clk                 (clk),
        .reset               (reset),
        .req0_valid          (req0_valid),
        .req0_ready          (req0_ready),
        .req0_opcode         (req0_opcode),
        .req0_op_a           (req0_op_a),
        .req0_op_b           (req0_op_b),
        .req1_valid          (req1_valid),
        .req1_ready          (req1_ready),
        .req1_opcode         (req1_opcode),
        .req1_op_a           (req1_op_a),
        .req1_op_b           (req1_op_b),
        .rd_req              (rd_req),
        .rd_valid            (rd_valid),
        .rd_word             (rd_word),
        .flush               (flush),
        .busy                (busy),
        .full                (full),
        .empty               (empty),
        .count               (count),
        .ir_load_en          (ir_load_en),
        .ir_write_pointer    (ir_write_pointer),
        .ir_opcode           (ir_opcode),
        .ir_operand_a        (ir_operand_a),
        .ir_operand_b        (ir_operand_b),
        .ir_read_pointer     (ir_read_pointer),
        .ir_instruction_word (ir_instruction_word)
    );

    // External register file driven by the controller's write port.
    always @(posedge clk) begin
        if (ir_load_en) begin
            mem[ir_write_pointer] <= {ir_opcode, ir_operand_a, ir_operand_b};
        end
    end
    assign ir_instruction_word = mem[ir_read_pointer];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks;
    int errors;

    bit           m_init;
    int           m_clr, m_wr, m_rd, m_cnt;
    bit           m_last;
    bit           m_rdv;
    instruction_t m_word;
    instruction_t sb_q[$];

    typedef struct {
        logic       v0;
        logic       v1;
        opcode_t    opc0;
        opcode_t    opc1;
        operand_t   a;
        logic [1:0] exp_rdy;
        int         exp_addr;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        req0_opcode = ZERO;
        req1_opcode = ZERO;
        req0_op_a   = '0;
        req0_op_b   = '0;
        req1_op_a   = '0;
        req1_op_b   = '0;
        rd_req      = 1'b0;
        flush       = 1'b0;
    endtask

    // One clock: check outputs against the model, then advance it.
    task automatic step();
        bit           g0, g1, acc, pop;
        instruction_t win;
        acc = 1'b0;
        g0  = 1'b0;
        g1  = 1'b0;
        win = '0;
        @(negedge clk);
        if (m_init) begin
            chk("busy_init", busy, 1'b1);
            chk("ld_init", ir_load_en, 1'b1);
            chk("wp_init", ir_write_pointer, m_clr);
            chk("clr_data", {ir_opcode, ir_operand_a, ir_operand_b}, '0);
            chk("rdy_init", {req1_ready, req0_ready}, 2'b00);
        end else begin
            g0  = req0_valid && (!req1_valid || m_last);
            g1  = req1_valid && !g0;
            acc = !flush && (m_cnt < N) && (g0 || g1);
            win = g0 ? {req0_opcode, req0_op_a, req0_op_b}
                     : {req1_opcode, req1_op_a, req1_op_b};
            chk("busy_run", busy, 1'b0);
            chk("rdy", {req1_ready, req0_ready}, {g1 && acc, g0 && acc});
            chk("ld", ir_load_en, acc);
            if (acc) begin
                chk("wp", ir_write_pointer, m_wr);
                chk("wdata", {ir_opcode, ir_operand_a, ir_operand_b}, win);
            end
        end
        chk("count", count, m_cnt);
        chk("full", full, m_cnt == N);
        chk("empty", empty, m_cnt == 0);
        chk("rd_ptr", ir_read_pointer, m_rd);
        chk("rd_valid", rd_valid, m_rdv);
        if (m_rdv) chk("rd_word", rd_word, m_word);
        @(posedge clk);
        if (m_init) begin
            m_rdv = 1'b0;
            m_clr++;
            if (m_clr == N) begin
                m_clr  = 0;
                m_init = 1'b0;
            end
        end else if (flush) begin
            m_wr   = 0;
            m_rd   = 0;
            m_cnt  = 0;
            m_rdv  = 1'b0;
            m_init = 1'b1;
            m_clr  = 0;
            sb_q.delete();
        end else begin
            pop   = rd_req && (m_cnt > 0);
            m_rdv = pop;
            if (pop) begin
                m_word = sb_q.pop_front();
                m_rd   = (m_rd + 1) % N;
            end
            if (acc) begin
                sb_q.push_back(win);
                m_wr   = (m_wr + 1) % N;
                m_last = g1;
            end
            m_cnt = m_cnt + int'(acc) - int'(pop);
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        @(negedge clk);
        chk("rst_busy", busy, 1'b1);
        chk("rst_ld", ir_load_en, 1'b0);
        chk("rst_rdy", {req1_ready, req0_ready}, 2'b00);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_word", rd_word, '0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        m_init = 1'b1;
        m_clr  = 0;
        m_wr   = 0;
        m_rd   = 0;
        m_cnt  = 0;
        m_last = 1'b1;
        m_rdv  = 1'b0;
        m_word = '0;
        sb_q.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;

        do_reset();
        repeat (N) step();
        step();

        tbl[0] = '{1'b1, 1'b1, ADD,  SUB, 32'sd11, 2'b01, 0};
        tbl[1] = '{1'b1, 1'b1, ADD,  SUB, 32'sd22, 2'b10, 1};
        tbl[2] = '{1'b1, 1'b1, MULT, DIV, 32'sd33, 2'b01, 2};
        tbl[3] = '{1'b1, 1'b1, MULT, DIV, 32'sd44, 2'b10, 3};
        for (int i = 0; i < 4; i++) begin
            req0_valid  = tbl[i].v0;
            req1_valid  = tbl[i].v1;
            req0_opcode = tbl[i].opc0;
            req1_opcode = tbl[i].opc1;
            req0_op_a   = tbl[i].a;
            req1_op_a   = -tbl[i].a;
            req0_op_b   = i;
            req1_op_b   = i + 100;
            #3;
            chk("tbl_rdy", {req1_ready, req0_ready}, tbl[i].exp_rdy);
            chk("tbl_addr", ir_write_pointer, tbl[i].exp_addr);
            step();
        end
        clear_inputs();
        #3;
        chk("tbl_count", count, 4);
        step();
        rd_req = 1'b1;
        repeat (4) step();
        rd_req = 1'b0;
        step();
        step();

        do_reset();
        repeat (N) step();
        req0_valid  = 1'b1;
        req0_opcode = ADD;
        for (int i = 0; i < N; i++) begin
            req0_op_a = operand_t'($urandom);
            req0_op_b = i;
            step();
        end
        req0_op_b = 99;
        #3;
        chk("full_set", full, 1'b1);
        step();
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        #3;
        chk("full_drop", full, 1'b0);
        chk("wrap_addr", ir_write_pointer, 0);
        chk("entry0_opb", rd_word.op_b, 0);
        step();
        req0_valid = 1'b0;
        rd_req     = 1'b1;
        repeat (N + 1) step();
        rd_req = 1'b0;
        step();

        rd_req      = 1'b1;
        req0_valid  = 1'b1;
        req0_opcode = SUB;
        req0_op_a   = -32'sd15;
        req0_op_b   = 32'sd15;
        step();
        req0_valid = 1'b0;
        step();
        rd_req = 1'b0;
        #3;
        chk("nb_valid", rd_valid, 1'b1);
        chk("nb_op_a", rd_word.op_a, -32'sd15);
        chk("nb_op_b", rd_word.op_b, 32'sd15);
        step();

        req0_valid  = 1'b1;
        req0_opcode = MULT;
        for (int i = 0; i < 5; i++) begin
            req0_op_a = i * 3;
            req0_op_b = i + 50;
            step();
        end
        #3;
        chk("pre_flush_cnt", count, 5);
        flush  = 1'b1;
        rd_req = 1'b1;
        step();
        rd_req     = 1'b0;
        req0_valid = 1'b0;
        #3;
        chk("flush_cnt", count, 0);
        chk("flush_busy", busy, 1'b1);
        chk("flush_rdv", rd_valid, 1'b0);
        repeat (5) step();
        flush = 1'b0;
        repeat (N - 5) step();
        req1_valid  = 1'b1;
        req1_opcode = DIV;
        req1_op_a   = 32'sd77;
        req1_op_b   = -32'sd7;
        step();
        req1_valid = 1'b0;
        rd_req     = 1'b1;
        step();
        rd_req = 1'b0;
        #3;
        chk("fresh_op_a", rd_word.op_a, 32'sd77);
        step();

        do_reset();
        repeat (17) step();
        #3;
        chk("clr_at17", ir_write_pointer, 17);
        do_reset();
        repeat (N) step();
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
